// File: rtl/ibc_rr.sv
// Round-robin input buffer controller: N read ports onto one in-order
// memory read channel, with credit-bounded outstanding reads.
module ibc_rr #(
  parameter int N_PORTS = 6,
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 8,
  parameter int ID_W    = $clog2(N_PORTS),
  parameter int CNT_W   = $clog2(DEPTH+1)
) (
  input  logic                      clk_bus,
  input  logic                      rst_bus,
  input  logic [N_PORTS-1:0]        req_vld,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr,
  output logic [N_PORTS-1:0]        req_rdy,
  output logic [ADDR_W-1:0]         mem_r_addr,
  output logic                      mem_r_vld,
  input  logic                      mem_r_rdy,
  input  logic [DATA_W-1:0]         mem_rsp_data,
  input  logic                      mem_rsp_vld,
  output logic [DATA_W-1:0]         pc_rsp_data,
  output logic [N_PORTS-1:0]        pc_rsp_vld,
  output logic [CNT_W-1:0]          inflight,
  output logic                      err_unexp_rsp
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [ID_W-1:0] LAST = ID_W'(N_PORTS-1);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt_id;
  logic [N_PORTS-1:0] gnt;
  logic               found;
  logic               accept_ok;
  logic               acc;
  logic               cmd_pop;
  logic               rsp_ok;
  logic [ADDR_W-1:0]  gnt_addr;

  logic [ADDR_W-1:0]  cmd_mem [DEPTH];
  logic [ID_W-1:0]    tag_mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      cmd_rp;
  logic [AW-1:0]      tag_rp;
  logic [CNT_W-1:0]   cmd_cnt;

  always_comb begin : arb
    int idx;
    idx    = 0;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!found && req_vld[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

  assign accept_ok = inflight < FULL;
  assign req_rdy   = (accept_ok && rst_bus) ? gnt : '0;
  assign acc       = found && accept_ok;
  assign gnt_addr  = req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];

  assign mem_r_vld   = cmd_cnt != '0;
  assign mem_r_addr  = cmd_mem[cmd_rp];
  assign cmd_pop     = mem_r_vld && mem_r_rdy;
  assign rsp_ok      = mem_rsp_vld && (inflight != '0);
  assign pc_rsp_data = mem_rsp_data;

  always_comb begin
    pc_rsp_vld = '0;
    if (rsp_ok) pc_rsp_vld[tag_mem[tag_rp]] = 1'b1;
  end

  // Both FIFOs push together, so they share one write pointer.
  always_ff @(posedge clk_bus) begin
    if (acc) begin
      cmd_mem[wr_ptr] <= gnt_addr;
      tag_mem[wr_ptr] <= gnt_id;
    end
  end

  always_ff @(posedge clk_bus or negedge rst_bus) begin
    if (!rst_bus) begin
      rr_ptr        <= '0;
      wr_ptr        <= '0;
      cmd_rp        <= '0;
      tag_rp        <= '0;
      cmd_cnt       <= '0;
      inflight      <= '0;
      err_unexp_rsp <= 1'b0;
    end else begin
      if (acc) begin
        wr_ptr <= wr_ptr + AW'(1);
        rr_ptr <= (gnt_id == LAST) ? '0
                : gnt_id + ID_W'(1);
      end
      if (cmd_pop) cmd_rp <= cmd_rp + AW'(1);
      if (rsp_ok)  tag_rp <= tag_rp + AW'(1);
      case ({acc, cmd_pop})
        2'b10:   cmd_cnt <= cmd_cnt + CNT_W'(1);
        2'b01:   cmd_cnt <= cmd_cnt - CNT_W'(1);
        default: cmd_cnt <= cmd_cnt;
      endcase
      case ({acc, rsp_ok})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
      if (mem_rsp_vld && inflight == '0)
        err_unexp_rsp <= 1'b1;
    end
  end

  always @(posedge clk_bus) begin
    if (rst_bus) begin
      assert (!(acc && cmd_cnt == FULL))
        else $error("cmd fifo overflow");
      assert (!(acc && !rsp_ok && inflight == FULL))
        else $error("tag fifo overflow");
      assert (cmd_cnt <= inflight)
        else $error("cmd occupancy above inflight");
    end
  end

endmodule

// File: doc/ibc_rr.md
Name: ibc_rr

Overview:
Parametrised next-generation input buffer controller. It sits between N_PORTS processing-core read ports and the single memory interface read channel. A round-robin arbiter accepts one read request per cycle, queues the address toward memory and records the port id of every outstanding request. In-order memory responses are routed back to the originating port. Outstanding reads are bounded by a credit counter, which replaces the old token-counter and dual-FIFO ping-pong scheme.

Parameters:
N_PORTS, 6, number of requesting ports; legal range 2..64.
ADDR_W, 28, read address width.
DATA_W, 64, read data width.
DEPTH, 8, maximum outstanding reads; power of two, at least 2; also the depth of both internal FIFOs.
ID_W, $clog2(N_PORTS), port-id tag width (derived; do not override).
CNT_W, $clog2(DEPTH+1), width of the inflight counter (derived).

Ports:
clk_bus  in  1  single clock; all logic on its rising edge.
rst_bus  in  1  asynchronous, active-low reset.
req_vld  in  N_PORTS  per-port read request valid.
req_addr  in  N_PORTS*ADDR_W  port i address occupies bits [i*ADDR_W +: ADDR_W].
req_rdy  out  N_PORTS  one-hot grant; a transfer occurs when req_vld[i] and req_rdy[i] are both high.
mem_r_addr  out  ADDR_W  address at the head of the command FIFO.
mem_r_vld  out  1  command FIFO not empty.
mem_r_rdy  in  1  memory accepts mem_r_addr.
mem_rsp_data  in  DATA_W  read data, returned in request order.
mem_rsp_vld  in  1  read data valid.
pc_rsp_data  out  DATA_W  mem_rsp_data passed through combinationally.
pc_rsp_vld  out  N_PORTS  one-hot response valid for the destination port.
inflight  out  CNT_W  requests accepted but not yet answered.
err_unexp_rsp  out  1  sticky flag: a response arrived while no request was outstanding.

Behaviour:
- Reset (rst_bus low, asynchronous):
  - rr_ptr=0, inflight=0, both FIFOs empty, err_unexp_rsp=0.
  - req_rdy=0, mem_r_vld=0, pc_rsp_vld=0 while reset is asserted.
  - Applying reset mid-operation discards all queued and outstanding state; late responses after reset set err_unexp_rsp.
- Credit check: accept_ok = (registered inflight < DEPTH). A response in the same cycle does not free a slot until the next cycle.
- Arbiter:
  - If accept_ok, req_rdy is one-hot on the first port with req_vld high, searching from rr_ptr upward and wrapping at N_PORTS-1 to 0. Otherwise req_rdy=0.
  - req_rdy is combinational from req_vld, rr_ptr and inflight.
  - On a transfer to port g: rr_ptr <= (g==N_PORTS-1) ? 0 : g+1. With no transfer, rr_ptr holds.
- Acceptance: the granted address is pushed into the command FIFO and g is pushed into the tag FIFO in the same cycle; inflight increments.
- Command path:
  - mem_r_vld = ~cmd_empty. An address accepted in cycle t appears on mem_r_addr in cycle t+1; there is no bypass.
  - The FIFO pops on mem_r_vld & mem_r_rdy.
  - While mem_r_rdy is low, mem_r_addr and mem_r_vld stay stable.
- Response path:
  - When mem_rsp_vld is high and inflight > 0: pc_rsp_vld[tag_head] = 1 in the same cycle (combinational), the tag FIFO pops and inflight decrements.
  - Accept and response in the same cycle: inflight is unchanged and the tag FIFO pushes and pops simultaneously.
  - When mem_rsp_vld is high and inflight == 0: the response is dropped, pc_rsp_vld stays 0 and err_unexp_rsp <= 1. The flag holds until reset.
- Invariants:
  - Command FIFO occupancy <= tag FIFO occupancy == inflight <= DEPTH.
  - Neither FIFO can overflow; assert this in simulation.
  - inflight never wraps.
- Width rules: tag values are 0..N_PORTS-1; pc_rsp_vld is a decode of an ID_W-bit tag. Unused tag codes never occur.

Test Plan:
1. Reset: drive 3 requests, then pull rst_bus low asynchronously between clock edges -> req_rdy, mem_r_vld, pc_rsp_vld and inflight are 0 immediately. After release, port 0 is granted first.
2. Fairness (N_PORTS=6, DEPTH=8, mem_r_rdy=1, responses 2 cycles after issue): all req_vld=6'h3F held -> grants follow ports 0,1,2,3,4,5,0,1...; each port gets exactly 2 of any 12 consecutive grants.
3. Backpressure (DEPTH=8): mem_r_rdy=0, ports 2 and 4 request with addresses 0x100 and 0x200 -> grants 2,4,2,4,2,4,2,4. Then req_rdy=0 and inflight=8; mem_r_addr holds 0x100 and mem_r_vld=1 until mem_r_rdy rises.
4. Routing: continuing scenario 3, release mem_r_rdy and return data 0xA0..0xA7 in order -> pc_rsp_vld = 6'b000100, 6'b010000 alternately with matching pc_rsp_data; inflight counts down to 0.
5. Full plus simultaneous events: with inflight=8, a response and req_vld[1] arrive in the same cycle -> no grant that cycle and inflight=7. Port 1 is granted the next cycle and inflight returns to 8.
6. Unexpected response: with inflight=0, pulse mem_rsp_vld with data 0xDEAD -> pc_rsp_vld=0, err_unexp_rsp=1 and it stays 1 through later traffic until rst_bus is asserted.
